// File: rtl/issue_scoreboard.sv
// issue_scoreboard
// In-order issue scoreboard for an RV32IM core. Decodes the offered
// instruction, detects RAW/WAW hazards against a per-register busy vector,
// tracks the non-pipelined MUL and DIV units, and reserves a unique writeback
// slot so that at most one result retires per cycle.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   inst         instruction word offered for issue
//   inst_valid   inst is valid this cycle
//   flush        cancel all in-flight state (suppresses issue this cycle)
//   issue_ready  offered instruction is consumed this cycle
//   issue        offered instruction is dispatched this cycle
//   fu_sel       functional unit of the offered instruction (0 ALU, 1 MEM, 2 MUL, 3 DIV)
//   illegal      offered instruction is not decodable
//   wb_valid     a result retires this cycle
//   wb_rd        destination register of the retiring result
//   wb_fu        functional unit of the retiring result
//   busy_regs    pending-write bit per register (bit 0 always 0)
//
// Latency parameters must lie in 1..15.
module issue_scoreboard #(
   parameter int ALU_LAT = 1,
   parameter int MEM_LAT = 2,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        inst_valid,
   input  logic        flush,
   output logic        issue_ready,
   output logic        issue,
   output logic [1:0]  fu_sel,
   output logic        illegal,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [1:0]  wb_fu,
   output logic [31:0] busy_regs
);

   localparam logic [1:0] FU_ALU = 2'd0;
   localparam logic [1:0] FU_MEM = 2'd1;
   localparam logic [1:0] FU_MUL = 2'd2;
   localparam logic [1:0] FU_DIV = 2'd3;

   localparam logic [3:0] ALU_LAT_C = 4'(ALU_LAT);
   localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);
   localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
   localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // instruction fields
   logic [6:0] opcode_s;
   logic [2:0] funct3_s;
   logic [6:0] funct7_s;
   logic [4:0] rs1_s;
   logic [4:0] rs2_s;
   logic [4:0] rd_s;

   // decode results
   logic [1:0] dec_fu_s;
   logic       dec_ill_s;
   logic       use_rs1_s;
   logic       use_rs2_s;
   logic       wr_class_s;
   logic       wr_rd_s;

   // writeback reservation shift register, entry 0 retires this cycle
   logic [14:0]      slot_vld_r;
   logic [14:0][4:0] slot_rd_r;
   logic [14:0][1:0] slot_fu_r;
   logic [14:0]      sh_vld_s;
   logic [14:0][4:0] sh_rd_s;
   logic [14:0][1:0] sh_fu_s;
   logic [14:0]      slot_vld_nxt_s;
   logic [14:0][4:0] slot_rd_nxt_s;
   logic [14:0][1:0] slot_fu_nxt_s;

   logic [31:0] busy_r;
   logic [31:0] busy_nxt_s;
   logic [31:0] clr_mask_s;
   logic [31:0] set_mask_s;
   logic [31:0] busy_ac_s;

   logic [3:0] mul_cnt_r;
   logic [3:0] div_cnt_r;
   logic [3:0] mul_cnt_nxt_s;
   logic [3:0] div_cnt_nxt_s;

   logic [3:0] lat_s;
   logic [3:0] slot_idx_s;
   logic       raw_s;
   logic       waw_s;
   logic       fu_free_s;
   logic       slot_free_s;
   logic       issue_s;

   assign opcode_s = inst[6:0];
   assign funct3_s = inst[14:12];
   assign funct7_s = inst[31:25];
   assign rs1_s    = inst[19:15];
   assign rs2_s    = inst[24:20];
   assign rd_s     = inst[11:7];

   // Decode: legality, functional unit class and register usage
   always_comb begin
      dec_fu_s   = FU_ALU;
      dec_ill_s  = 1'b0;
      use_rs1_s  = 1'b0;
      use_rs2_s  = 1'b0;
      wr_class_s = 1'b0;
      case (opcode_s)
         OP_R: begin
            use_rs1_s  = 1'b1;
            use_rs2_s  = 1'b1;
            wr_class_s = 1'b1;
            if (funct7_s == F7_MULDIV) begin
               // funct3[2] splits the M extension into multiply and divide groups
               if (funct3_s[2] == 1'b1) begin
                  dec_fu_s = FU_DIV;
               end else begin
                  dec_fu_s = FU_MUL;
               end
            end else if (funct7_s == F7_BASE) begin
               dec_fu_s = FU_ALU;
            end else if ((funct7_s == F7_ALT) &&
                         ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
               dec_fu_s = FU_ALU;
            end else begin
               dec_ill_s = 1'b1;
            end
         end
         OP_IMM: begin
            use_rs1_s  = 1'b1;
            wr_class_s = 1'b1;
            // shift-immediates constrain the upper bits; the rest take any immediate
            if (funct3_s == 3'b001) begin
               dec_ill_s = (funct7_s != F7_BASE);
            end else if (funct3_s == 3'b101) begin
               dec_ill_s = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
            end else begin
               dec_ill_s = 1'b0;
            end
         end
         OP_LOAD: begin
            dec_fu_s   = FU_MEM;
            use_rs1_s  = 1'b1;
            wr_class_s = 1'b1;
            dec_ill_s  = (funct3_s == 3'b011) || (funct3_s == 3'b110) ||
                         (funct3_s == 3'b111);
         end
         OP_STORE: begin
            dec_fu_s  = FU_MEM;
            use_rs1_s = 1'b1;
            use_rs2_s = 1'b1;
            dec_ill_s = (funct3_s[2] == 1'b1) || (funct3_s == 3'b011);
         end
         OP_BRANCH: begin
            use_rs1_s = 1'b1;
            use_rs2_s = 1'b1;
            dec_ill_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
         end
         OP_LUI: begin
            wr_class_s = 1'b1;
         end
         OP_AUIPC: begin
            wr_class_s = 1'b1;
         end
         OP_JAL: begin
            wr_class_s = 1'b1;
         end
         OP_JALR: begin
            use_rs1_s  = 1'b1;
            wr_class_s = 1'b1;
            dec_ill_s  = (funct3_s != 3'b000);
         end
         default: begin
            dec_ill_s = 1'b1;
         end
      endcase
   end

   assign wr_rd_s = wr_class_s & (rd_s != 5'd0);

   // Latency of the decoded functional unit
   always_comb begin
      case (dec_fu_s)
         FU_ALU:  lat_s = ALU_LAT_C;
         FU_MEM:  lat_s = MEM_LAT_C;
         FU_MUL:  lat_s = MUL_LAT_C;
         FU_DIV:  lat_s = DIV_LAT_C;
         default: lat_s = ALU_LAT_C;
      endcase
   end

   // Shift-register contents as they will be after this cycle's advance
   assign sh_vld_s = {1'b0, slot_vld_r[14:1]};
   assign sh_rd_s  = {5'd0, slot_rd_r[14:1]};
   assign sh_fu_s  = {2'd0, slot_fu_r[14:1]};

   assign slot_idx_s  = lat_s - 4'd1;
   assign slot_free_s = ~wr_rd_s | ~sh_vld_s[slot_idx_s];

   // Busy bit of the register retiring this cycle, removed before hazard checks
   always_comb begin
      if (slot_vld_r[0]) begin
         clr_mask_s = 32'd1 << slot_rd_r[0];
      end else begin
         clr_mask_s = 32'd0;
      end
   end

   assign busy_ac_s = busy_r & ~clr_mask_s;
   assign raw_s = (use_rs1_s & busy_ac_s[rs1_s]) | (use_rs2_s & busy_ac_s[rs2_s]);
   assign waw_s = wr_rd_s & busy_ac_s[rd_s];

   // A counter of 1 reaches 0 at this edge, so the unit can accept a new op now;
   // this lets an L-cycle unit take back-to-back ops every L cycles.
   always_comb begin
      case (dec_fu_s)
         FU_MUL:  fu_free_s = (mul_cnt_r <= 4'd1);
         FU_DIV:  fu_free_s = (div_cnt_r <= 4'd1);
         default: fu_free_s = 1'b1;
      endcase
   end

   assign issue_s = inst_valid & ~dec_ill_s & ~flush & ~rst & ~raw_s & ~waw_s &
                    fu_free_s & slot_free_s;

   assign issue       = issue_s;
   assign issue_ready = issue_s | (inst_valid & dec_ill_s & ~flush & ~rst);
   assign illegal     = inst_valid & dec_ill_s;
   assign fu_sel      = dec_fu_s;
   assign wb_valid    = slot_vld_r[0];
   assign wb_rd       = slot_rd_r[0];
   assign wb_fu       = slot_fu_r[0];
   assign busy_regs   = busy_r;

   // Next shift-register contents: advance, then reserve the issuing instruction's slot
   always_comb begin
      slot_vld_nxt_s = sh_vld_s;
      slot_rd_nxt_s  = sh_rd_s;
      slot_fu_nxt_s  = sh_fu_s;
      set_mask_s     = 32'd0;
      if (issue_s && wr_rd_s) begin
         slot_vld_nxt_s[slot_idx_s] = 1'b1;
         slot_rd_nxt_s[slot_idx_s]  = rd_s;
         slot_fu_nxt_s[slot_idx_s]  = dec_fu_s;
         set_mask_s                 = 32'd1 << rd_s;
      end else begin
         set_mask_s = 32'd0;
      end
   end

   // Set is applied after clear so a same-cycle re-issue keeps the register busy
   assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

   // Non-pipelined unit occupancy counters
   always_comb begin
      if (issue_s && (dec_fu_s == FU_MUL)) begin
         mul_cnt_nxt_s = MUL_LAT_C;
      end else if (mul_cnt_r != 4'd0) begin
         mul_cnt_nxt_s = mul_cnt_r - 4'd1;
      end else begin
         mul_cnt_nxt_s = 4'd0;
      end
      if (issue_s && (dec_fu_s == FU_DIV)) begin
         div_cnt_nxt_s = DIV_LAT_C;
      end else if (div_cnt_r != 4'd0) begin
         div_cnt_nxt_s = div_cnt_r - 4'd1;
      end else begin
         div_cnt_nxt_s = 4'd0;
      end
   end

   // Writeback reservation register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_vld_r <= 15'd0;
         slot_rd_r  <= '0;
         slot_fu_r  <= '0;
      end else if (flush) begin
         slot_vld_r <= 15'd0;
         slot_rd_r  <= '0;
         slot_fu_r  <= '0;
      end else begin
         slot_vld_r <= slot_vld_nxt_s;
         slot_rd_r  <= slot_rd_nxt_s;
         slot_fu_r  <= slot_fu_nxt_s;
      end
   end

   // Pending-write register vector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 32'd0;
      end else if (flush) begin
         busy_r <= 32'd0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // MUL and DIV occupancy counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_cnt_r <= 4'd0;
         div_cnt_r <= 4'd0;
      end else if (flush) begin
         mul_cnt_r <= 4'd0;
         div_cnt_r <= 4'd0;
      end else begin
         mul_cnt_r <= mul_cnt_nxt_s;
         div_cnt_r <= div_cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard. A reference model keeps the
// in-flight results as a list of {due cycle, rd, fu} records and the cycle at
// which each non-pipelined unit becomes free; expected outputs are derived
// from that list every cycle.
module tb_issue_scoreboard;

   localparam int ALU_L = 1;
   localparam int MEM_L = 2;
   localparam int MUL_L = 3;
   localparam int DIV_L = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        inst_valid;
   logic        flush;
   logic        issue_ready;
   logic        issue;
   logic [1:0]  fu_sel;
   logic        illegal;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_fu;
   logic [31:0] busy_regs;

   issue_scoreboard #(
      .ALU_LAT(ALU_L), .MEM_LAT(MEM_L), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)
   ) dut (
      .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .flush(flush),
      .issue_ready(issue_ready), .issue(issue), .fu_sel(fu_sel), .illegal(illegal),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fu(wb_fu), .busy_regs(busy_regs)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int rd;
      int fu;
   } wb_t;

   wb_t pend[$];
   int  mul_free;
   int  div_free;
   int  cyc;
   int  n_checks;
   int  n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic int lat_of(input int fu);
      case (fu)
         0: return ALU_L;
         1: return MEM_L;
         2: return MUL_L;
         default: return DIV_L;
      endcase
   endfunction

   // Reference classification from the RV32IM instruction tables
   function automatic void ref_decode(input logic [31:0] w, output int fu, output bit ill,
                                      output bit u1, output bit u2, output bit wr);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      fu = 0; ill = 1'b0; u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
      if (op == 7'h33) begin
         u1 = 1; u2 = 1; wr = 1;
         if (f7 == 7'h01) fu = (f3 < 3'd4) ? 2 : 3;
         else if (f7 == 7'h00) fu = 0;
         else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) fu = 0;
         else ill = 1;
      end else if (op == 7'h13) begin
         u1 = 1; wr = 1;
         if (f3 == 3'd1) ill = (f7 != 7'h00);
         else if (f3 == 3'd5) ill = !(f7 == 7'h00 || f7 == 7'h20);
      end else if (op == 7'h03) begin
         fu = 1; u1 = 1; wr = 1;
         ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end else if (op == 7'h23) begin
         fu = 1; u1 = 1; u2 = 1;
         ill = (f3 > 3'd2);
      end else if (op == 7'h63) begin
         u1 = 1; u2 = 1;
         ill = (f3 == 3'd2 || f3 == 3'd3);
      end else if (op == 7'h37 || op == 7'h17 || op == 7'h6f) begin
         wr = 1;
      end else if (op == 7'h67) begin
         u1 = 1; wr = 1;
         ill = (f3 != 3'd0);
      end else begin
         ill = 1;
      end
      if (w[11:7] == 5'd0) wr = 0;
   endfunction

   // One clock cycle: drive at posedge+1, compare at the following negedge
   task automatic do_cycle(input logic v, input logic [31:0] w, input logic f, output bit took);
      int fu, lat;
      bit ill, u1, u2, wr, slot_ok, fu_ok, e_issue, e_ready;
      logic [31:0] e_busy, after_clr;
      logic e_wbv;
      logic [4:0] e_wbrd;
      logic [1:0] e_wbfu;
      wb_t keep[$];
      inst_valid = v; inst = w; flush = f;
      #4;
      ref_decode(w, fu, ill, u1, u2, wr);
      lat = lat_of(fu);
      e_wbv = 1'b0; e_wbrd = 5'd0; e_wbfu = 2'd0;
      e_busy = 32'd0; after_clr = 32'd0; slot_ok = 1'b1;
      foreach (pend[i]) begin
         if (pend[i].due == cyc) begin
            e_wbv = 1'b1; e_wbrd = 5'(pend[i].rd); e_wbfu = 2'(pend[i].fu);
         end
         if (pend[i].due >= cyc) e_busy[pend[i].rd] = 1'b1;
         if (pend[i].due > cyc) after_clr[pend[i].rd] = 1'b1;
         if (wr && pend[i].due == cyc + lat) slot_ok = 1'b0;
      end
      fu_ok = (fu == 2) ? (cyc >= mul_free) : (fu == 3) ? (cyc >= div_free) : 1'b1;
      e_issue = v && !ill && !f && !(u1 && after_clr[w[19:15]]) &&
                !(u2 && after_clr[w[24:20]]) && !(wr && after_clr[w[11:7]]) && fu_ok && slot_ok;
      e_ready = e_issue || (v && ill && !f);
      check("issue", {31'd0, issue}, {31'd0, e_issue});
      check("issue_ready", {31'd0, issue_ready}, {31'd0, e_ready});
      check("illegal", {31'd0, illegal}, {31'd0, (v && ill)});
      check("wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
      check("busy_regs", busy_regs, e_busy);
      if (e_wbv) begin
         check("wb_rd", {27'd0, wb_rd}, {27'd0, e_wbrd});
         check("wb_fu", {30'd0, wb_fu}, {30'd0, e_wbfu});
      end
      if (e_issue) check("fu_sel", {30'd0, fu_sel}, 32'(fu));
      if (f) begin
         pend.delete();
         mul_free = 0;
         div_free = 0;
      end else begin
         foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
         pend = keep;
         if (e_issue) begin
            if (wr) pend.push_back('{cyc + lat, int'(w[11:7]), fu});
            if (fu == 2) mul_free = cyc + lat;
            if (fu == 3) div_free = cyc + lat;
         end
      end
      took = e_ready;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      bit took;
      for (int k = 0; k < n; k++) do_cycle(1'b0, 32'd0, 1'b0, took);
   endtask

   // Offer an instruction until it is consumed; returns the consuming cycle
   task automatic offer(input logic [31:0] w, output int at);
      bit took;
      at = -1;
      for (int k = 0; k < 20; k++) begin
         do_cycle(1'b1, w, 1'b0, took);
         if (took) begin
            at = cyc - 1;
            break;
         end
      end
      n_checks++;
      assert (at >= 0) else begin
         n_fail++;
         $error("FAIL offer_timeout observed=no_issue expected=issue word=%h", w);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; inst_valid = 1'b1; inst = 32'h0020_82B3; flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #4;
         check("rst_issue", {31'd0, issue}, 32'd0);
         check("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
         check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
         check("rst_busy", busy_regs, 32'd0);
         @(posedge clk);
         #1;
         cyc++;
      end
      rst = 1'b0;
      pend.delete();
      mul_free = 0;
      div_free = 0;
   endtask

   function automatic logic [31:0] rinst(input int k, input logic [4:0] a, input logic [4:0] b,
                                         input logic [4:0] d, input logic [2:0] f3);
      case (k)
         0: return {(f3 == 3'd0) ? 7'h20 : 7'h00, b, a, f3, d, 7'h33};
         1: return {12'h07f, a, 3'b000, d, 7'h13};
         2: return {12'd4, a, 3'b010, d, 7'h03};
         3: return {7'd0, b, a, 3'b010, 5'd0, 7'h23};
         4: return {7'd0, b, a, 3'b000, 5'd0, 7'h63};
         5: return {7'h01, b, a, {1'b0, f3[1:0]}, d, 7'h33};
         6: return {7'h01, b, a, {1'b1, f3[1:0]}, d, 7'h33};
         7: return {20'h12345, d, 7'h37};
         8: return {12'd0, a, 3'b000, d, 7'h67};
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int t0, t1, t2, t3;
      bit took;
      rst = 1'b1; inst = 32'd0; inst_valid = 1'b0; flush = 1'b0;
      cyc = 0; n_checks = 0; n_fail = 0; mul_free = 0; div_free = 0;
      @(posedge clk);
      #1;
      do_reset();
      idle(2);

      // ADD x5,x1,x2 then ADD x6,x5,x5: dependent op issues next cycle
      offer(32'h0020_82B3, t0);
      offer(32'h0052_8333, t1);
      check("raw_same_cycle_clear", 32'(t1), 32'(t0 + 1));
      idle(4);

      // MUL x3 ; LW x7,4(x0) stalls on slot ; MUL x9 waits for the MUL unit
      offer({7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, t0);
      offer({12'd4, 5'd0, 3'b010, 5'd7, 7'h03}, t1);
      offer({7'h01, 5'd2, 5'd1, 3'b000, 5'd9, 7'h33}, t2);
      check("lw_slot_stall", 32'(t1), 32'(t0 + 2));
      check("mul_fu_free", 32'(t2), 32'(t0 + 3));
      idle(6);

      // DIV x4 then ADDI x4,x0,1: WAW stall until the DIV retires
      offer({7'h01, 5'd2, 5'd1, 3'b100, 5'd4, 7'h33}, t0);
      offer({12'd1, 5'd0, 3'b000, 5'd4, 7'h13}, t1);
      check("waw_div_addi", 32'(t1), 32'(t0 + DIV_L));
      #4;
      check("busy4_kept", {31'd0, busy_regs[4]}, 32'd1);
      #6;
      idle(3);

      // Writes to x0 never reserve anything
      offer(32'h0020_8033, t0);
      offer(32'h0000_00B3, t1);
      check("x0_back2back", 32'(t1), 32'(t0 + 1));
      idle(3);

      // Illegal word consumed without dispatch
      do_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, took);
      check("illegal_consumed", {31'd0, took}, 32'd1);
      idle(2);

      // DIV x8, flush two cycles later, new DIV right after
      offer({7'h01, 5'd2, 5'd1, 3'b101, 5'd8, 7'h33}, t0);
      idle(1);
      do_cycle(1'b0, 32'd0, 1'b1, took);
      offer({7'h01, 5'd2, 5'd1, 3'b110, 5'd10, 7'h33}, t3);
      check("div_after_flush", 32'(t3), 32'(t0 + 3));
      idle(10);

      // Randomized traffic with a mid-run reset
      for (int i = 0; i < 600; i++) begin
         logic [4:0] a, b, d;
         logic [2:0] f3;
         int k;
         logic v, f;
         if (i == 300) do_reset();
         k  = $urandom_range(0, 9);
         a  = 5'($urandom_range(0, 7));
         b  = 5'($urandom_range(0, 7));
         d  = 5'($urandom_range(0, 7));
         f3 = 3'($urandom_range(0, 7));
         v  = ($urandom_range(0, 3) != 0);
         f  = ($urandom_range(0, 29) == 0);
         do_cycle(v, rinst(k, a, b, d, f3), f, took);
      end
      idle(16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
